// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter for the ALU BITSHIFT group (11_00xx): one bit position per clock,
// with valid/ready request and response handshakes.
`timescale 1ns/1ps
module alu_serial_shifter #(
  parameter int WORDSIZE = 64,
  parameter int SHAMT_W  = $clog2(WORDSIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WORDSIZE-1:0] input_a,
  input  logic [WORDSIZE-1:0] input_b,
  input  logic [5:0]          operation,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WORDSIZE-1:0] out,
  output logic                illegal_op,
  output logic                busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic [WORDSIZE-1:0] sreg;
  logic [WORDSIZE-1:0] step;
  logic [SHAMT_W-1:0]  count;
  logic                right_q;
  logic                arith_q;
  logic                ill_q;
  logic                hold_q;
  logic                legal;
  logic                unused_b;

  assign legal      = (operation[5:2] == 4'b1100);
  assign unused_b   = ^input_b[WORDSIZE-1:SHAMT_W];
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  always_comb begin
    step = sreg;
    if (!hold_q) begin
      if (right_q) step = {arith_q & sreg[WORDSIZE-1], sreg[WORDSIZE-1:1]};
      else         step = {sreg[WORDSIZE-2:0], 1'b0};
    end
  end

  // Zero-amount and illegal requests pass through SHIFT once without shifting,
  // so the response always arrives max(n,1) edges after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sreg       <= '0;
      count      <= '0;
      right_q    <= 1'b0;
      arith_q    <= 1'b0;
      ill_q      <= 1'b0;
      hold_q     <= 1'b0;
      out        <= '0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            sreg    <= input_a;
            right_q <= ~operation[0];
            arith_q <= ~operation[1];
            ill_q   <= ~legal;
            hold_q  <= ~legal | (input_b[SHAMT_W-1:0] == '0);
            count   <= legal ? input_b[SHAMT_W-1:0] : '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= step;
          if (count != '0) count <= count - 1'b1;
          if (count == '0 || count == SHAMT_W'(1)) begin
            out        <= ill_q ? '0 : step;
            illegal_op <= ill_q;
            state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_shifter.sv
// Directed and randomized checks of alu_serial_shifter against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_serial_shifter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] input_a;
  logic [63:0] input_b;
  logic [5:0]  operation;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] out;
  logic        illegal_op;
  logic        busy;

  int errors = 0;
  int checks = 0;

  alu_serial_shifter #(.WORDSIZE(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .input_a(input_a), .input_b(input_b), .operation(operation),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .out(out),
    .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_out(input logic [63:0] a, input logic [63:0] b,
                                             input logic [5:0] op);
    int n;
    logic [63:0] r;
    n = int'(b % 64);
    case (op)
      6'b110000: r = $signed(a) >>> n;
      6'b110001: r = a << n;
      6'b110010: r = a >> n;
      6'b110011: r = a << n;
      default:   r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [63:0] b, input logic [5:0] op);
    int n;
    n = int'(b % 64);
    if (op[5:2] != 4'b1100) return 1;
    return (n == 0) ? 1 : n;
  endfunction

  task automatic scramble();
    input_a   = {$urandom, $urandom};
    input_b   = {$urandom, $urandom};
    operation = 6'($urandom);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "_idle_rdy"}, 64'(req_ready), 64'd1);
    check({tag, "_idle_vld"}, 64'(resp_valid), 64'd0);
  endtask

  task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic [5:0] op, input int hold);
    logic [63:0] eo;
    int el;
    int lat;
    int w;
    eo = model_out(a, b, op);
    el = model_lat(b, op);
    @(negedge clk);
    input_a = a; input_b = b; operation = op; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_accept"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    wait_resp(lat);
    check({tag, "_lat"}, 64'(lat), 64'(el));
    check({tag, "_out"}, out, eo);
    check({tag, "_ill"}, 64'(illegal_op), 64'(op[5:2] != 4'b1100));
    check({tag, "_busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_out"}, out, eo);
      check({tag, "_hold_vld"}, 64'(resp_valid), 64'd1);
    end
    handshake(tag);
  endtask

  initial begin
    logic [63:0] a1;
    logic [63:0] a2;
    logic [5:0]  op;
    int lat;
    int pick;
    int bad;

    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    input_a = '0; input_b = '0; operation = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      scramble();
      req_valid  = 1'($urandom);
      resp_ready = 1'($urandom);
      @(posedge clk); #1;
      check("rst_rdy", 64'(req_ready), 64'd1);
      check("rst_vld", 64'(resp_valid), 64'd0);
      check("rst_out", out, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;

    run("lsl5", 64'h1, 64'd5, 6'b110011, 4);
    run("asr4", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFC4, 6'b110000, 0);
    run("lsr4", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFC4, 6'b110010, 0);
    run("asl0", 64'hDEAD_BEEF, 64'd0, 6'b110001, 1);
    run("lsr63", '1, 64'd63, 6'b110010, 0);
    run("illegal", {$urandom, $urandom}, 64'd17, 6'b100101, 2);
    run("after_ill", 64'h0123_4567_89AB_CDEF, 64'd3, 6'b110011, 0);

    // Reset 10 cycles into a 40-position shift.
    @(negedge clk);
    input_a = {$urandom, $urandom}; input_b = 64'd40; operation = 6'b110010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_rdy", 64'(req_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out", out, 64'd0);
    @(negedge clk);
    reset = 1'b0; resp_ready = 1'b1;
    bad = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (resp_valid) bad++;
    end
    resp_ready = 1'b0;
    check("abort_no_resp", 64'(bad), 64'd0);

    // Request held while busy must not disturb the one in flight.
    a1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    @(negedge clk);
    input_a = a1; input_b = 64'd10; operation = 6'b110011; req_valid = 1'b1;
    @(posedge clk); #1;
    input_a = a2; input_b = 64'd3; operation = 6'b110000;
    bad = 0; lat = 0;
    while (!resp_valid && lat < 300) begin
      if (req_ready) bad++;
      @(posedge clk); #1;
      lat++;
    end
    check("busy_rdy_low", 64'(bad), 64'd0);
    check("busy_lat", 64'(lat), 64'd10);
    check("busy_out", out, model_out(a1, 64'd10, 6'b110011));
    repeat (2) begin
      @(posedge clk); #1;
      check("busy_wait_vld", 64'(resp_valid), 64'd1);
    end
    handshake("busy_first");
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pend_accepted", 64'(busy), 64'd1);
    wait_resp(lat);
    check("pend_lat", 64'(lat), 64'd3);
    check("pend_out", out, model_out(a2, 64'd3, 6'b110000));
    handshake("pend");

    for (int i = 0; i < 24; i++) begin
      pick = $urandom_range(0, 5);
      if (pick < 4) op = {4'b1100, 2'(pick)};
      else begin
        op = 6'($urandom);
        if (op[5:2] == 4'b1100) op[5] = 1'b0;
      end
      run("rand", {$urandom, $urandom}, {$urandom, $urandom}, op, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
